// File: rtl/calc_pkg.sv
// Shared types and constants for the keypad calculator core.
// Controller states, operator one-hot codes and an operator validity helper.
package calc_pkg;

    typedef enum logic [1:0] {
        S_OP1    = 2'd0,
        S_OP2    = 2'd1,
        S_MUL    = 2'd2,
        S_RESULT = 2'd3
    } calc_state_t;

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b100;

    function automatic logic is_valid_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/seq_mult.sv
// Sequential shift-add signed multiplier: one multiplier bit per cycle,
// finish pulses WIDTH cycles after start with the full 2*WIDTH product.
module seq_mult #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_finish,
    output logic [2*WIDTH-1:0]   o_product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_cnt;
    logic               r_finish;
    logic [2*WIDTH-1:0] w_addend;

    assign w_addend  = r_mplier[0] ? r_mcand : '0;
    assign o_finish  = r_finish;
    assign o_product = r_acc;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_finish <= 1'b0;
        end else begin
            r_finish <= 1'b0;
            if (i_abort) begin
                r_cnt <= '0;
            end else if (i_start) begin
                r_mcand  <= {{WIDTH{i_a[WIDTH-1]}}, i_a};
                r_mplier <= i_b;
                r_acc    <= '0;
                r_cnt    <= CW'(WIDTH);
            end else if (r_cnt != '0) begin
                // The multiplier MSB carries negative weight in two's complement.
                r_acc    <= (r_cnt == CW'(1)) ? (r_acc - w_addend) : (r_acc + w_addend);
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) r_finish <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/calc_core.sv
// Keypad calculator controller: decimal operand entry, sign toggle, add/sub
// in one cycle and multiply through the sequential seq_mult unit.
module calc_core
    import calc_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 4
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic [3:0]       keypad_input,
    input  logic             read_input,
    input  logic [2:0]       operator_input,
    input  logic             negate_input,
    input  logic             equal_input,
    input  logic             clear_input,
    output logic [WIDTH-1:0] display_output,
    output logic             complete,
    output logic             busy,
    output logic             overflow,
    output calc_state_t      state_out
);

    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam logic [WIDTH+3:0] MAG_LIMIT = {5'b00000, {(WIDTH-1){1'b1}}};

    calc_state_t      r_state;
    logic [WIDTH-1:0] r_mag;
    logic             r_neg;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_op1;
    logic [2:0]       r_opcode;
    logic [WIDTH-1:0] r_result;
    logic             r_overflow;
    logic             r_read_d;
    logic             r_mul_start;

    logic [WIDTH-1:0]   w_entry, w_sum, w_diff;
    logic [WIDTH+3:0]   w_mag_ext, w_new_mag;
    logic [2*WIDTH-1:0] w_product;
    logic [WIDTH:0]     w_prod_hi;
    logic               w_mul_finish, w_digit_ok, w_add_ovf, w_sub_ovf, w_mul_ovf;
    logic               w_take_op, w_take_neg, w_take_digit;

    // Sign is kept apart from the magnitude so later digits extend the magnitude.
    assign w_entry   = r_neg ? (~r_mag + 1'b1) : r_mag;
    assign w_mag_ext = {4'b0000, r_mag};
    assign w_new_mag = (w_mag_ext << 3) + (w_mag_ext << 1) + {{WIDTH{1'b0}}, keypad_input};
    assign w_digit_ok = (keypad_input <= 4'd9) && (r_cnt < CW'(MAX_DIGITS)) && (w_new_mag <= MAG_LIMIT);

    assign w_sum     = r_op1 + w_entry;
    assign w_diff    = r_op1 - w_entry;
    assign w_add_ovf = (r_op1[WIDTH-1] == w_entry[WIDTH-1]) && (w_sum[WIDTH-1] != r_op1[WIDTH-1]);
    assign w_sub_ovf = (r_op1[WIDTH-1] != w_entry[WIDTH-1]) && (w_diff[WIDTH-1] != r_op1[WIDTH-1]);
    assign w_prod_hi = w_product[2*WIDTH-1:WIDTH-1];
    assign w_mul_ovf = !((&w_prod_hi) || !(|w_prod_hi));

    // Event priority below clear: equal > operator > negate > digit edge.
    assign w_take_op    = !equal_input && is_valid_op(operator_input);
    assign w_take_neg   = !equal_input && !is_valid_op(operator_input) && negate_input;
    assign w_take_digit = !equal_input && !is_valid_op(operator_input) && !negate_input
                          && read_input && !r_read_d;

    seq_mult #(.WIDTH(WIDTH)) u_mult (
        .clk       (clk),
        .rst_n     (nRST),
        .i_start   (r_mul_start),
        .i_abort   (clear_input),
        .i_a       (r_op1),
        .i_b       (w_entry),
        .o_finish  (w_mul_finish),
        .o_product (w_product)
    );

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_state     <= S_OP1;
            r_mag       <= '0;
            r_neg       <= 1'b0;
            r_cnt       <= '0;
            r_op1       <= '0;
            r_opcode    <= '0;
            r_result    <= '0;
            r_overflow  <= 1'b0;
            r_read_d    <= 1'b0;
            r_mul_start <= 1'b0;
        end else begin
            r_read_d    <= read_input;
            r_mul_start <= 1'b0;
            if (clear_input) begin
                r_state    <= S_OP1;
                r_mag      <= '0;
                r_neg      <= 1'b0;
                r_cnt      <= '0;
                r_op1      <= '0;
                r_opcode   <= '0;
                r_result   <= '0;
                r_overflow <= 1'b0;
            end else begin
                case (r_state)
                    S_OP1, S_OP2: begin
                        if (equal_input) begin
                            if (r_state == S_OP2 && r_cnt != '0) begin
                                if (r_opcode == OP_MUL) begin
                                    r_state     <= S_MUL;
                                    r_mul_start <= 1'b1;
                                end else begin
                                    r_result   <= (r_opcode == OP_ADD) ? w_sum : w_diff;
                                    r_overflow <= (r_opcode == OP_ADD) ? w_add_ovf : w_sub_ovf;
                                    r_state    <= S_RESULT;
                                end
                            end
                        end else if (w_take_op) begin
                            if (r_state == S_OP1 && r_cnt != '0) begin
                                r_op1    <= w_entry;
                                r_opcode <= operator_input;
                                r_mag    <= '0;
                                r_neg    <= 1'b0;
                                r_cnt    <= '0;
                                r_state  <= S_OP2;
                            end else if (r_state == S_OP2 && r_cnt == '0) begin
                                r_opcode <= operator_input;
                            end
                        end else if (w_take_neg) begin
                            r_neg <= ~r_neg;
                        end else if (w_take_digit && w_digit_ok) begin
                            r_mag <= w_new_mag[WIDTH-1:0];
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    S_MUL: begin
                        if (w_mul_finish) begin
                            r_result   <= w_product[WIDTH-1:0];
                            r_overflow <= w_mul_ovf;
                            r_state    <= S_RESULT;
                        end
                    end
                    S_RESULT: begin
                        if (w_take_op) begin
                            r_op1      <= r_result;
                            r_opcode   <= operator_input;
                            r_mag      <= '0;
                            r_neg      <= 1'b0;
                            r_cnt      <= '0;
                            r_overflow <= 1'b0;
                            r_state    <= S_OP2;
                        end else if (w_take_digit && keypad_input <= 4'd9) begin
                            r_mag      <= {{(WIDTH-4){1'b0}}, keypad_input};
                            r_neg      <= 1'b0;
                            r_cnt      <= CW'(1);
                            r_overflow <= 1'b0;
                            r_state    <= S_OP1;
                        end
                    end
                    default: r_state <= S_OP1;
                endcase
            end
        end
    end

    assign display_output = (r_state == S_RESULT) ? r_result : w_entry;
    assign complete       = (r_state == S_RESULT);
    assign busy           = (r_state == S_MUL);
    assign overflow       = r_overflow && (r_state == S_RESULT);
    assign state_out      = r_state;

endmodule

// File: doc/calc_core.md
CALC_CORE -- requirements
Module: calc_core

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width, two's complement signed.
REQ-002 SHALL have parameter MAX_DIGITS, default 4: maximum decimal digits accepted per operand.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port keypad_input  input  4  digit value; only 0-9 are valid.
REQ-006 SHALL have port read_input  input  1  digit strobe (level, may be held many cycles).
REQ-007 SHALL have port operator_input  input  3  one-hot: 001 add, 010 sub, 100 mul; other codes mean no operator.
REQ-008 SHALL have port negate_input  input  1  toggles the sign of the operand being entered.
REQ-009 SHALL have port equal_input  input  1  request computation.
REQ-010 SHALL have port clear_input  input  1  synchronous clear to the entry start.
REQ-011 SHALL have port display_output  output  WIDTH  current operand or result.
REQ-012 SHALL have port complete  output  1  high while a result is shown.
REQ-013 SHALL have port busy  output  1  high while a multiply runs.
REQ-014 SHALL have port overflow  output  1  signed overflow of the shown result.
REQ-015 SHALL have port state_out  output  calc_state_t  current state, for benches.

Function
REQ-016 SHALL implement states S_OP1, S_OP2, S_MUL and S_RESULT.
REQ-017 SHALL accept a digit only on the rising edge of read_input (internal edge detect); a held strobe gives one digit.
REQ-018 SHALL update the entered operand as op = op*10 + digit in the accepting cycle (shift-add, single cycle), visible on display_output the next cycle.
REQ-019 SHALL ignore a digit if it is >9, if MAX_DIGITS digits are already held, or if the new magnitude exceeds 2^(WIDTH-1)-1.
REQ-020 SHALL, on negate_input in S_OP1/S_OP2, negate the displayed operand; sign is retained through further digits, which are applied to the magnitude.
REQ-021 SHALL, in S_OP1 with at least one digit, on a valid one-hot operator latch the operator and go to S_OP2 with operand2 = 0 and digit count 0; otherwise ignore the operator.
REQ-022 SHALL, in S_OP2, replace the latched operator if a new valid one arrives before any operand2 digit.
REQ-023 SHALL, in S_OP2 with at least one digit, on equal_input: for add/sub go to S_RESULT next cycle; for mul start seq_mult and go to S_MUL.
REQ-024 SHALL, in S_MUL, hold busy=1 and go to S_RESULT the cycle after seq_mult finish; complete rises exactly WIDTH+2 cycles after the equal-accepting edge.
REQ-025 SHALL set overflow for add/sub on signed overflow, and for mul when the 2*WIDTH product is not the sign extension of its low WIDTH bits; display_output shows the low WIDTH bits.
REQ-026 SHALL, in S_RESULT, hold complete=1; a digit starts a fresh operand1 in S_OP1; an operator chains the result as operand1 and enters S_OP2; equal is ignored.
REQ-027 SHALL, on clear_input in any state, next cycle zero both operands, counts, complete, overflow and busy, abort any multiply and enter S_OP1.
REQ-028 SHALL, for simultaneous events in one cycle, apply priority clear > equal > operator > negate > digit, acting on the highest only.
REQ-029 SHALL ignore read_input, operator_input, negate_input and equal_input while in S_MUL.

Reset
REQ-030 SHALL, when nRST is low, asynchronously force S_OP1, display_output=0, complete=0, busy=0, overflow=0, operands=0, digit counts=0 and edge-detect history=0, including mid-multiply.

Structure
REQ-031 SHALL take calc_state_t and the operator one-hot constants from the shared package calc_pkg.
REQ-032 SHALL instantiate one sub-module seq_mult (WIDTH-parameterised shift-add signed multiplier, start/finish pulse handshake, finish WIDTH cycles after start, 2*WIDTH product).

Verification
REQ-033 SHALL cover: 1,2 + 3,4 = -> display 46 (0x002E), complete=1, overflow=0.
REQ-034 SHALL cover: 7 - 2,0 = -> display 0xFFF3 (-13), overflow=0.
REQ-035 SHALL cover: 3,0,0 * 2,0,0 = -> busy=1 for the multiply, complete at equal+18 cycles, display 0xEA60, overflow=1.
REQ-036 SHALL cover: digits 1,2,3,4,5 with read_input held 3 cycles each -> operand 1234; negate -> 0xFB2E.
REQ-037 SHALL cover chaining: after result 46, * 2 = -> display 92.
REQ-038 SHALL cover clear and nRST asserted mid-multiply -> S_OP1, busy=0, display 0 (next cycle for clear, immediately for reset).
